// File: rtl/id_pkg.sv
// Shared definitions for the ID-stage operand fetch and hazard logic.
// Optional build macro: ID_STALL_PERF_EN (enables the stall performance counter).
package id_pkg;

    localparam logic [3:0] REG_INVALID = 4'hF;
    localparam logic [3:0] REG_SP      = 4'hE;
    localparam logic [3:0] REG_T       = 4'hD;

    // Register write effect of an accepted instruction on the scoreboard.
    typedef enum logic [1:0] {
        RWE_NONE = 2'd0,
        RWE_ALU  = 2'd1,
        RWE_LOAD = 2'd2
    } rwe_t;

    // Low bit of tap `tap` inside a flattened per-tap bus of `width`-bit fields.
    function automatic int tap_lo(input int tap, input int width);
        return tap * width;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register load scoreboard: countdown of cycles until an in-flight load result is bypassable.
// Optional build macro: none (see id_hazard_unit for ID_STALL_PERF_EN).
module id_scoreboard
    import id_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [REG_AW-1:0] wreg,
    input  logic              is_load,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREG = 1 << REG_AW;
    localparam int CW   = $clog2(LOAD_LAT + 1);
    localparam logic [REG_AW-1:0] INV = REG_AW'(REG_INVALID);

    rwe_t            rwe;
    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] busy_vec;

    always_comb begin
        rwe = RWE_NONE;
        if (accept && (wreg != INV)) begin
            rwe = is_load ? RWE_LOAD : RWE_ALU;
        end
    end

    // A fresh issue to a register overrides its decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if ((rwe != RWE_NONE) && (wreg == REG_AW'(r))) begin
                    cnt[r] <= (rwe == RWE_LOAD) ? CW'(LOAD_LAT) : '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_vec[gi] = (cnt[gi] != '0);
        end
    endgenerate

    assign busy1 = (rs1_addr != INV) && busy_vec[rs1_addr];
    assign busy2 = (rs2_addr != INV) && busy_vec[rs2_addr];

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage operand bypass (nearest tap wins) plus load-use stall and stall statistics.
// Optional build macro: ID_STALL_PERF_EN enables the 32-bit wrapping stall counter.
module id_hazard_unit
    import id_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int RUN_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REG_AW-1:0]             rs1_addr,
    input  logic [REG_AW-1:0]             rs2_addr,
    input  logic [DATA_W-1:0]             rf1_data,
    input  logic [DATA_W-1:0]             rf2_data,
    input  logic [FWD_DEPTH-1:0]          fwd_valid,
    input  logic [FWD_DEPTH*REG_AW-1:0]   fwd_reg,
    input  logic [FWD_DEPTH*DATA_W-1:0]   fwd_data,
    input  logic                          iss_valid,
    input  logic [REG_AW-1:0]             iss_wreg,
    input  logic                          iss_is_load,
    output logic [DATA_W-1:0]             op1_data,
    output logic [DATA_W-1:0]             op2_data,
    output logic                          stall,
    output logic                          iss_accept,
    output logic [RUN_W-1:0]              stall_run,
    output logic [31:0]                   perf_stall_cnt
);

    localparam logic [REG_AW-1:0] INV     = REG_AW'(REG_INVALID);
    localparam logic [RUN_W-1:0]  RUN_MAX = '1;

    logic [REG_AW-1:0]    tap_reg [FWD_DEPTH];
    logic [DATA_W-1:0]    tap_dat [FWD_DEPTH];
    logic [FWD_DEPTH-1:0] hit1;
    logic [FWD_DEPTH-1:0] hit2;
    logic                 busy1;
    logic                 busy2;
    logic [RUN_W-1:0]     run_reg;

    genvar gi;
    generate
        for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_tap
            assign tap_reg[gi] = fwd_reg[tap_lo(gi, REG_AW) +: REG_AW];
            assign tap_dat[gi] = fwd_data[tap_lo(gi, DATA_W) +: DATA_W];
            assign hit1[gi]    = fwd_valid[gi] && (tap_reg[gi] == rs1_addr);
            assign hit2[gi]    = fwd_valid[gi] && (tap_reg[gi] == rs2_addr);
        end
    endgenerate

    // Walk from the farthest tap inward so the nearest match is applied last.
    always_comb begin
        op1_data = rf1_data;
        op2_data = rf2_data;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (hit1[i] && (rs1_addr != INV)) op1_data = tap_dat[i];
            if (hit2[i] && (rs2_addr != INV)) op2_data = tap_dat[i];
        end
    end

    id_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .accept   (iss_accept),
        .wreg     (iss_wreg),
        .is_load  (iss_is_load),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    assign stall      = busy1 | busy2;
    assign iss_accept = iss_valid & ~stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_reg <= '0;
        end else if (stall) begin
            if (run_reg != RUN_MAX) run_reg <= run_reg + RUN_W'(1);
        end else begin
            run_reg <= '0;
        end
    end

    assign stall_run = run_reg;

`ifdef ID_STALL_PERF_EN
    logic [31:0] perf_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_reg <= '0;
        end else if (stall) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_reg;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Self-checking bench for id_hazard_unit: bypass vector table plus load-use/override/reset sequences.
// Three instances share stimulus: LOAD_LAT 1, LOAD_LAT 3, and LOAD_LAT 5 with a 2-bit stall_run.
module tb_id_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rs1, rs2;
    logic [15:0] rf1, rf2;
    logic [2:0]  fv;
    logic [11:0] freg;
    logic [47:0] fdata;
    logic        iss_valid;
    logic [3:0]  iss_wreg;
    logic        iss_load;

    logic [15:0] a_op1, a_op2, b_op1, b_op2, c_op1, c_op2;
    logic        a_stall, a_acc, b_stall, b_acc, c_stall, c_acc;
    logic [3:0]  a_run, b_run;
    logic [1:0]  c_run;
    logic [31:0] a_perf, b_perf, c_perf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_hazard_unit #(.LOAD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .rs1_addr(rs1), .rs2_addr(rs2), .rf1_data(rf1), .rf2_data(rf2),
        .fwd_valid(fv), .fwd_reg(freg), .fwd_data(fdata), .iss_valid(iss_valid),
        .iss_wreg(iss_wreg), .iss_is_load(iss_load), .op1_data(a_op1), .op2_data(a_op2),
        .stall(a_stall), .iss_accept(a_acc), .stall_run(a_run), .perf_stall_cnt(a_perf));

    id_hazard_unit #(.LOAD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .rs1_addr(rs1), .rs2_addr(rs2), .rf1_data(rf1), .rf2_data(rf2),
        .fwd_valid(fv), .fwd_reg(freg), .fwd_data(fdata), .iss_valid(iss_valid),
        .iss_wreg(iss_wreg), .iss_is_load(iss_load), .op1_data(b_op1), .op2_data(b_op2),
        .stall(b_stall), .iss_accept(b_acc), .stall_run(b_run), .perf_stall_cnt(b_perf));

    id_hazard_unit #(.LOAD_LAT(5), .RUN_W(2)) u_c (
        .clk(clk), .rst(rst), .rs1_addr(rs1), .rs2_addr(rs2), .rf1_data(rf1), .rf2_data(rf2),
        .fwd_valid(fv), .fwd_reg(freg), .fwd_data(fdata), .iss_valid(iss_valid),
        .iss_wreg(iss_wreg), .iss_is_load(iss_load), .op1_data(c_op1), .op2_data(c_op2),
        .stall(c_stall), .iss_accept(c_acc), .stall_run(c_run), .perf_stall_cnt(c_perf));

    typedef struct {
        int          sel;
        string       tag;
        logic [15:0] op1;
        logic [15:0] op2;
        logic        stall;
        logic        acc;
        logic [3:0]  run;
        logic [31:0] perf;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [3:0]  rs1, rs2;
        logic [15:0] rf1, rf2;
        logic [2:0]  fv;
        logic [11:0] freg;
        logic [47:0] fdata;
        logic [15:0] e1, e2;
    } vec_t;

    vec_t vt[6];

    function automatic logic [31:0] pf(input int n);
`ifdef ID_STALL_PERF_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, req);
        end
    endtask

    task automatic check_rec(input exp_t e);
        logic [15:0] o1, o2;
        logic        st, ac;
        logic [3:0]  rn;
        logic [31:0] pc;
        case (e.sel)
            0:       begin o1 = a_op1; o2 = a_op2; st = a_stall; ac = a_acc; rn = a_run; pc = a_perf; end
            1:       begin o1 = b_op1; o2 = b_op2; st = b_stall; ac = b_acc; rn = b_run; pc = b_perf; end
            default: begin o1 = c_op1; o2 = c_op2; st = c_stall; ac = c_acc; rn = {2'b00, c_run}; pc = c_perf; end
        endcase
        $display("[%0t] %s dut%0d op1=%h op2=%h stall=%b acc=%b run=%0d perf=%0d",
                 $time, e.tag, e.sel, o1, o2, st, ac, rn, pc);
        cmp(e.tag, "op1", {16'h0, o1}, {16'h0, e.op1});
        cmp(e.tag, "op2", {16'h0, o2}, {16'h0, e.op2});
        cmp(e.tag, "stall", {31'h0, st}, {31'h0, e.stall});
        cmp(e.tag, "iss_accept", {31'h0, ac}, {31'h0, e.acc});
        cmp(e.tag, "stall_run", {28'h0, rn}, {28'h0, e.run});
        cmp(e.tag, "perf", pc, e.perf);
    endtask

    task automatic push(input int sel, input string tag, input logic [15:0] o1, input logic [15:0] o2,
                        input logic st, input logic ac, input logic [3:0] rn, input logic [31:0] pc);
        exp_t e;
        e.sel = sel; e.tag = tag; e.op1 = o1; e.op2 = o2;
        e.stall = st; e.acc = ac; e.run = rn; e.perf = pc;
        q.push_back(e);
    endtask

    // Compare everything expected for this cycle, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        while (q.size() > 0) check_rec(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 4'hF; rs2 = 4'hF; rf1 = 16'h1111; rf2 = 16'h2222;
        fv = 3'b000; freg = 12'h000; fdata = 48'h0;
        iss_valid = 1'b0; iss_wreg = 4'hF; iss_load = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Issue a load to register r (expected to be accepted on the listed instances).
    task automatic issue_load(input logic [3:0] r);
        idle_inputs();
        iss_valid = 1'b1; iss_wreg = r; iss_load = 1'b1;
    endtask

    initial begin
        vt[0] = '{4'h3, 4'hF, 16'h1234, 16'h5555, 3'b000, 12'h000, 48'h0, 16'h1234, 16'h5555};
        vt[1] = '{4'h3, 4'h0, 16'h1234, 16'h5555, 3'b101, 12'h303,
                  {16'hBBBB, 16'hCCCC, 16'hAAAA}, 16'hAAAA, 16'h5555};
        vt[2] = '{4'h3, 4'h0, 16'h1234, 16'h5555, 3'b100, 12'h303,
                  {16'hBBBB, 16'hCCCC, 16'hAAAA}, 16'hBBBB, 16'h5555};
        vt[3] = '{4'h3, 4'h0, 16'h1234, 16'h5555, 3'b010, 12'h303,
                  {16'hBBBB, 16'hCCCC, 16'hAAAA}, 16'h1234, 16'hCCCC};
        vt[4] = '{4'hF, 4'h1, 16'h7777, 16'h8888, 3'b011, 12'h01F,
                  {16'h0000, 16'h0D0D, 16'hF0F0}, 16'h7777, 16'h0D0D};
        vt[5] = '{4'h1, 4'h2, 16'h7777, 16'h8888, 3'b110, 12'h210,
                  {16'h2222, 16'h1111, 16'h9999}, 16'h1111, 16'h2222};

        // Reset defaults with an issue that writes nothing.
        do_reset();
        rs1 = 4'h3; rf1 = 16'h1234; iss_valid = 1'b1;
        push(0, "reset", 16'h1234, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();

        // Bypass table.
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            rs1 = vt[i].rs1; rs2 = vt[i].rs2; rf1 = vt[i].rf1; rf2 = vt[i].rf2;
            fv = vt[i].fv; freg = vt[i].freg; fdata = vt[i].fdata;
            push(0, $sformatf("vec%0d", i), vt[i].e1, vt[i].e2, 1'b0, 1'b0, 4'd0, 32'd0);
            tick();
        end

        // Invalid source with a loaded REG_INVALID write attempt.
        issue_load(4'hF);
        push(0, "inv_ld", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        rs1 = 4'hF; fv = 3'b001; freg = 12'h00F; fdata = 48'h0000_0000_F00D;
        push(0, "inv_src", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();

        // Load-use, LOAD_LAT=1; a load attempted while stalled must not land.
        do_reset();
        issue_load(4'h2);
        push(0, "ll1_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        rs2 = 4'h2; fv = 3'b001; freg = 12'h002; fdata = 48'h0000_0000_00C3;
        iss_valid = 1'b1; iss_wreg = 4'h7; iss_load = 1'b1;
        push(0, "ll1_t1", 16'h1111, 16'h00C3, 1'b1, 1'b0, 4'd0, 32'd0);
        tick();
        iss_valid = 1'b0; rs1 = 4'h7;
        push(0, "ll1_t2", 16'h1111, 16'h00C3, 1'b0, 1'b0, 4'd1, pf(1));
        tick();
        push(0, "ll1_t3", 16'h1111, 16'h00C3, 1'b0, 1'b0, 4'd0, pf(1));
        tick();

        // Load-use, LOAD_LAT=3 (u_b) and LOAD_LAT=5 with saturating 2-bit run (u_c).
        do_reset();
        issue_load(4'h2);
        push(1, "ll3_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        push(2, "ll5_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        rs2 = 4'h2; fv = 3'b001; freg = 12'h002; fdata = 48'h0000_0000_00C3;
        for (int k = 1; k <= 7; k++) begin
            int rb, rc;
            rb = (k == 1 || k > 4) ? 0 : k - 1;
            rc = (k == 1 || k > 6) ? 0 : ((k - 1 > 3) ? 3 : k - 1);
            push(1, $sformatf("ll3_t%0d", k), 16'h1111, 16'h00C3, k <= 3, 1'b0, 4'(rb),
                 pf((k - 1 > 3) ? 3 : k - 1));
            push(2, $sformatf("ll5_t%0d", k), 16'h1111, 16'h00C3, k <= 5, 1'b0, 4'(rc),
                 pf((k - 1 > 5) ? 5 : k - 1));
            tick();
        end

        // Reset asserted mid-stall discards the in-flight load.
        do_reset();
        issue_load(4'h2);
        push(1, "rst_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        rs2 = 4'h2; fv = 3'b001; freg = 12'h002; fdata = 48'h0000_0000_00C3;
        rst = 1'b0;
        push(1, "rst_t1", 16'h1111, 16'h00C3, 1'b1, 1'b0, 4'd0, 32'd0);
        tick();
        rst = 1'b1;
        push(1, "rst_t2", 16'h1111, 16'h00C3, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();

        // Newer ALU writer supersedes an in-flight load.
        do_reset();
        issue_load(4'h5);
        push(0, "ovr_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        push(1, "ovr_t0", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        iss_valid = 1'b1; iss_wreg = 4'h5; iss_load = 1'b0;
        push(0, "ovr_t1", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        push(1, "ovr_t1", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'd0, 32'd0);
        tick();
        idle_inputs();
        rs1 = 4'h5; fv = 3'b001; freg = 12'h005; fdata = 48'h0000_0000_5A5A;
        push(0, "ovr_t2", 16'h5A5A, 16'h2222, 1'b0, 1'b0, 4'd0, 32'd0);
        push(1, "ovr_t2", 16'h5A5A, 16'h2222, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_unit.md
# id_hazard_unit

Parametrised operand-fetch and hazard block for the ID stage of the 16-bit pipeline. It resolves both source operands of the instruction in decode through a configurable-depth bypass network, with the nearest stage winning. A registered load scoreboard with a configurable load latency raises a stall while any source is still waiting on an in-flight load. It replaces the fixed three-stage forward and single-cycle load-use logic with one block whose forwarding depth, data width and load latency are generic.

## Interface
- DATA_W, 16: operand/result width.
- REG_AW, 4: register address width; 2^REG_AW scoreboard entries.
- FWD_DEPTH, 3: number of downstream result taps; tap 0 is nearest (EX), tap FWD_DEPTH-1 is farthest.
- LOAD_LAT, 1: cycles after a load issues during which its destination is unavailable (range 1..7).
- RUN_W, 4: width of the consecutive-stall counter.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- rs1_addr, rs2_addr  in  REG_AW  source registers of the decoded instruction; REG_INVALID means unused.
- rf1_data, rf2_data  in  DATA_W  register-file read data for rs1/rs2.
- fwd_valid  in  FWD_DEPTH  tap i holds a pending register write.
- fwd_reg  in  FWD_DEPTH*REG_AW  tap i destination at [i*REG_AW +: REG_AW].
- fwd_data  in  FWD_DEPTH*DATA_W  tap i result at [i*DATA_W +: DATA_W].
- iss_valid  in  1  decode presents an instruction for issue.
- iss_wreg  in  REG_AW  destination of the issuing instruction; REG_INVALID means no write.
- iss_is_load  in  1  issuing instruction is a memory load.
- op1_data, op2_data  out  DATA_W  resolved operands (combinational).
- stall  out  1  hold IF/ID and insert a bubble (combinational from registered state).
- iss_accept  out  1  iss_valid & ~stall.
- stall_run  out  RUN_W  registered count of consecutive stall cycles, saturating.
- perf_stall_cnt  out  32  total stall cycles (see Configuration).

## Operation
- Operand select per source, evaluated independently:
  - If addr == REG_INVALID, the operand is rfN_data and the source never stalls.
  - Otherwise the lowest tap i with fwd_valid[i] & fwd_reg[i]==addr supplies the operand.
  - With no matching tap, rfN_data supplies the operand.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1), all 0 at reset.
  - On iss_accept with iss_wreg != REG_INVALID:
    - If iss_is_load, cnt[iss_wreg] <= LOAD_LAT.
    - Otherwise cnt[iss_wreg] <= 0 (newer non-load writer supersedes; forwarding supplies it).
  - All other nonzero counters decrement by 1 every cycle.
  - Simultaneous load issue and decrement on the same register: issue wins.
- stall = (rs1 valid & cnt[rs1]!=0) | (rs2 valid & cnt[rs2]!=0). REG_INVALID entry is never set.
- While stalled, iss_accept=0, so no scoreboard write occurs; counters keep decrementing.
- stall_run: +1 per stall cycle, saturating at 2^RUN_W-1; cleared to 0 on the first non-stall cycle.

## Timing
- Reset values: all counters 0, stall_run 0, perf_stall_cnt 0, hence stall=0 and iss_accept=iss_valid.
- Load accepted at edge t to Rk: a consumer of Rk stalls in cycles t+1 … t+LOAD_LAT and proceeds at t+LOAD_LAT+1, taking its operand from the bypass.
- Operands and stall are zero-cycle combinational; scoreboard and counters have one-cycle latency.
- Reset asserted mid-stall clears the stall at the next edge; in-flight load tracking is discarded.

## Configuration
- ID_STALL_PERF_EN defined: a 32-bit free-running counter increments on every stall cycle and wraps at 2^32. It drives perf_stall_cnt and is reset to 0.
- Not defined: no counter logic; perf_stall_cnt tied to 0.

## Structure
- Shared package id_pkg holds:
  - REG_INVALID (4'hF), REG_SP, REG_T.
  - The RWE encodings.
  - A function for the bypass tap index slice.
- Sub-module id_scoreboard holds the counter array, issue/decrement update and the two busy lookups. The top level holds the bypass muxes, stall_run and the perf counter.

## Test plan
- Defaults. Reset, rs1=3, rf1=0x1234, no taps valid -> op1=0x1234, stall=0, stall_run=0.
- Tap priority. Tap0 reg3=0xAAAA and tap2 reg3=0xBBBB both valid, rs1=3 -> op1=0xAAAA; drop tap0 -> op1=0xBBBB.
- Load-use, LOAD_LAT=1. Accept load to R2 at t, then rs2=2 -> stall=1 at t+1. At t+2: stall=0, op2=tap value 0x00C3.
- Load-use, LOAD_LAT=3. Same sequence -> stall for 3 cycles, stall_run 1,2,3, then 0 on release. With ID_STALL_PERF_EN, perf_stall_cnt=3.
- Invalid source. rs1=0xF with tap0 reg 0xF valid and loaded -> op1=rf1_data, stall=0.
- Override. Load to R5 accepted at t, ALU write to R5 accepted at t+1 (sources unrelated). rs1=5 at t+2 -> stall=0, op1 from tap0.
